// File: rtl/riscv_checkpoint_monitor_if.sv
// ---------------------------------------------------------------------------
// riscv_checkpoint_monitor_if
// Bundles every non-clock signal of the checkpoint monitor.
//   master : the side that loads the table, pulses start and forwards the
//            core's retired-instruction count, output port and halt.
//   slave  : the monitor itself; it drives the sticky status outputs.
// Signals:
//   cfg_we/cfg_addr/cfg_num_inst/cfg_ans : table write port
//   cfg_num_valid                        : valid entry count, taken on start
//   start                                : one-cycle run request
//   num_inst/output_port/halt            : observed core state
//   busy/done/pass/fail                  : run status
//   fail_code/fail_idx/fail_value        : first-failure record
//   fail_cnt/pass_cnt/cycle_cnt          : run counters
// ---------------------------------------------------------------------------
interface riscv_checkpoint_monitor_if #(
  parameter int NUM_CKPT  = 40,
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 32
);
  localparam int AW = $clog2(NUM_CKPT);
  localparam int CW = $clog2(NUM_CKPT + 1);

  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic [CNT_WIDTH-1:0] cfg_num_inst;
  logic [DWIDTH-1:0]    cfg_ans;
  logic [CW-1:0]        cfg_num_valid;
  logic                 start;
  logic [CNT_WIDTH-1:0] num_inst;
  logic [DWIDTH-1:0]    output_port;
  logic                 halt;

  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 fail;
  logic [2:0]           fail_code;
  logic [AW-1:0]        fail_idx;
  logic [DWIDTH-1:0]    fail_value;
  logic [CW-1:0]        fail_cnt;
  logic [CW-1:0]        pass_cnt;
  logic [CNT_WIDTH-1:0] cycle_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_num_inst, cfg_ans, cfg_num_valid, start,
           num_inst, output_port, halt,
    input  busy, done, pass, fail, fail_code, fail_idx, fail_value,
           fail_cnt, pass_cnt, cycle_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_num_inst, cfg_ans, cfg_num_valid, start,
           num_inst, output_port, halt,
    output busy, done, pass, fail, fail_code, fail_idx, fail_value,
           fail_cnt, pass_cnt, cycle_cnt
  );
endinterface

// File: rtl/riscv_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// riscv_checkpoint_monitor
// Watches the core's retired-instruction count and output port and checks
// them against a loadable table of (instruction count, expected value)
// checkpoints. Reports pass / fail / timeout through sticky status outputs.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (table contents are preserved)
//   mon    : riscv_checkpoint_monitor_if.slave (config, core view, status)
// Parameters:
//   NUM_CKPT     : table depth
//   DWIDTH       : width of the output port and expected values
//   CNT_WIDTH    : width of instruction counts and the cycle counter
//   TIMEOUT      : RUN cycles before a timeout failure (0 disables)
//   STOP_ON_FAIL : 1 ends the run at the first failure, 0 keeps checking
// ---------------------------------------------------------------------------
module riscv_checkpoint_monitor #(
  parameter int NUM_CKPT     = 40,
  parameter int DWIDTH       = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int TIMEOUT      = 1000000,
  parameter int STOP_ON_FAIL = 1
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  riscv_checkpoint_monitor_if.slave    mon
);

  localparam int AW = $clog2(NUM_CKPT);
  localparam int CW = $clog2(NUM_CKPT + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  localparam logic [2:0] CODE_MISMATCH = 3'd1;
  localparam logic [2:0] CODE_SKIPPED  = 3'd2;
  localparam logic [2:0] CODE_HALT     = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Checkpoint table: plain register array, written only outside RUN.
  logic [CNT_WIDTH-1:0] tbl_num_q [NUM_CKPT];
  logic [DWIDTH-1:0]    tbl_ans_q [NUM_CKPT];

  state_t               state_q;
  logic [CW-1:0]        nvalid_q;
  // ptr needs CW bits: it reaches nvalid (up to NUM_CKPT) once all entries
  // are consumed.
  logic [CW-1:0]        ptr_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 fail_q;
  logic [2:0]           fail_code_q;
  logic [AW-1:0]        fail_idx_q;
  logic [DWIDTH-1:0]    fail_value_q;
  logic [CW-1:0]        fail_cnt_q;
  logic [CW-1:0]        pass_cnt_q;
  logic [CNT_WIDTH-1:0] cycle_cnt_q;

  // Next-state values for a RUN cycle.
  logic                 entry_valid;
  logic [CNT_WIDTH-1:0] entry_num;
  logic [DWIDTH-1:0]    entry_ans;
  logic                 entry_hit;
  logic                 entry_skip;
  logic                 entry_mis;
  logic                 entry_fail;
  logic [CW-1:0]        ptr_d;
  logic                 halt_short;
  logic [CW-1:0]        missing_cnt;
  logic [CNT_WIDTH-1:0] cycle_cnt_d;
  logic                 timeout_hit;
  logic                 run_end;
  logic                 pass_d;
  logic                 fail_d;
  logic [2:0]           fail_code_d;
  logic [AW-1:0]        fail_idx_d;
  logic [DWIDTH-1:0]    fail_value_d;
  logic [CW-1:0]        fail_cnt_d;
  logic [CW-1:0]        pass_cnt_d;
  logic [CW-1:0]        nvalid_d;

  // -------------------------------------------------------------------------
  // Table write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (mon.cfg_we && (state_q != S_RUN) && (int'(mon.cfg_addr) < NUM_CKPT)) begin
      tbl_num_q[mon.cfg_addr] <= mon.cfg_num_inst;
      tbl_ans_q[mon.cfg_addr] <= mon.cfg_ans;
    end
  end

  // -------------------------------------------------------------------------
  // RUN-cycle evaluation
  // -------------------------------------------------------------------------
  always_comb begin
    entry_valid = (ptr_q < nvalid_q);
    // Index only matters while entry_valid, which implies ptr_q < NUM_CKPT.
    entry_num   = tbl_num_q[ptr_q[AW-1:0]];
    entry_ans   = tbl_ans_q[ptr_q[AW-1:0]];
    entry_hit   = entry_valid && (mon.num_inst == entry_num);
    entry_skip  = entry_valid && (mon.num_inst > entry_num);
    entry_mis   = entry_hit && (mon.output_port != entry_ans);
    entry_fail  = entry_mis || entry_skip;

    // At most one entry is consumed per cycle, even if the count jumped
    // past several of them.
    ptr_d       = ptr_q + CW'(entry_hit || entry_skip);

    // HALT is judged against the post-compare pointer.
    halt_short  = mon.halt && (ptr_d < nvalid_q);
    missing_cnt = halt_short ? (nvalid_q - ptr_d) : '0;

    cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
    // HALT wins over a same-cycle timeout.
    timeout_hit = (TIMEOUT != 0) && !mon.halt && (cycle_cnt_d == TIMEOUT_C);

    pass_cnt_d  = pass_cnt_q + CW'(entry_hit && !entry_mis);
    fail_cnt_d  = fail_cnt_q + CW'(entry_fail) + missing_cnt + CW'(timeout_hit);
    fail_d      = fail_q || entry_fail || halt_short || timeout_hit;

    // First-failure capture; the entry compare has priority over a
    // same-cycle HALT or timeout failure.
    fail_code_d  = fail_code_q;
    fail_idx_d   = fail_idx_q;
    fail_value_d = fail_value_q;
    if (!fail_q) begin
      if (entry_fail) begin
        fail_code_d  = entry_mis ? CODE_MISMATCH : CODE_SKIPPED;
        fail_idx_d   = ptr_q[AW-1:0];
        fail_value_d = mon.output_port;
      end else if (halt_short) begin
        fail_code_d  = CODE_HALT;
        fail_idx_d   = ptr_d[AW-1:0];
        fail_value_d = mon.output_port;
      end else if (timeout_hit) begin
        fail_code_d  = CODE_TIMEOUT;
        fail_idx_d   = ptr_d[AW-1:0];
        fail_value_d = mon.output_port;
      end
    end

    run_end = mon.halt || timeout_hit || ((STOP_ON_FAIL != 0) && entry_fail);
    pass_d  = mon.halt && !halt_short && !fail_q && !entry_fail;

    // A valid count above the table depth is clamped to the table depth.
    nvalid_d = (int'(mon.cfg_num_valid) > NUM_CKPT) ? CW'(NUM_CKPT) : mon.cfg_num_valid;
  end

  // -------------------------------------------------------------------------
  // FSM and status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      nvalid_q     <= '0;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= '0;
      fail_idx_q   <= '0;
      fail_value_q <= '0;
      fail_cnt_q   <= '0;
      pass_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (mon.start) begin
            state_q      <= S_RUN;
            nvalid_q     <= nvalid_d;
            ptr_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= '0;
            fail_idx_q   <= '0;
            fail_value_q <= '0;
            fail_cnt_q   <= '0;
            pass_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
          end
        end
        S_RUN: begin
          ptr_q        <= ptr_d;
          pass_cnt_q   <= pass_cnt_d;
          fail_cnt_q   <= fail_cnt_d;
          fail_q       <= fail_d;
          fail_code_q  <= fail_code_d;
          fail_idx_q   <= fail_idx_d;
          fail_value_q <= fail_value_d;
          cycle_cnt_q  <= cycle_cnt_d;
          if (run_end) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= pass_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mon.busy       = busy_q;
  assign mon.done       = done_q;
  assign mon.pass       = pass_q;
  assign mon.fail       = fail_q;
  assign mon.fail_code  = fail_code_q;
  assign mon.fail_idx   = fail_idx_q;
  assign mon.fail_value = fail_value_q;
  assign mon.fail_cnt   = fail_cnt_q;
  assign mon.pass_cnt   = pass_cnt_q;
  assign mon.cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// Bench for riscv_checkpoint_monitor. Two instances share all stimulus: one
// stops at the first failure, the other keeps checking. Directed vectors
// carry hand-derived expectations; randomized runs are checked against a
// run-level reference model working from the table and the input history.
// ---------------------------------------------------------------------------
module tb_riscv_checkpoint_monitor;
  localparam int NCK  = 40;
  localparam int DW   = 32;
  localparam int CNTW = 32;
  localparam int TMO  = 20;
  localparam int LEN  = 22;

  typedef struct {
    int done, busy, pass, fail, code, idx, fcnt, pcnt, cyc, done_at;
    longint value;
  } exp_t;

  typedef struct {
    string name;
    int    nv, halt_n, skip_n, bad_n, freeze;
    exp_t  e1, e0;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_checkpoint_monitor_if #(.NUM_CKPT(NCK), .DWIDTH(DW), .CNT_WIDTH(CNTW)) if1 ();
  riscv_checkpoint_monitor_if #(.NUM_CKPT(NCK), .DWIDTH(DW), .CNT_WIDTH(CNTW)) if0 ();

  riscv_checkpoint_monitor #(.NUM_CKPT(NCK), .DWIDTH(DW), .CNT_WIDTH(CNTW),
                             .TIMEOUT(TMO), .STOP_ON_FAIL(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mon(if1));
  riscv_checkpoint_monitor #(.NUM_CKPT(NCK), .DWIDTH(DW), .CNT_WIDTH(CNTW),
                             .TIMEOUT(TMO), .STOP_ON_FAIL(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .mon(if0));

  int n_checks = 0;
  int n_fail   = 0;

  int     tnum [NCK];
  longint tans [NCK];
  int     s_num  [LEN];
  longint s_out  [LEN];
  int     s_halt [LEN];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(int done, int pass, int fail, int code, int idx,
                              longint value, int fcnt, int pcnt, int done_at);
    exp_t e;
    e.done = done; e.busy = 0; e.pass = pass; e.fail = fail; e.code = code;
    e.idx = idx; e.value = value; e.fcnt = fcnt; e.pcnt = pcnt;
    e.done_at = done_at; e.cyc = done_at + 1;
    return e;
  endfunction

  function automatic exp_t snap1(int done_at);
    exp_t g;
    g.done = int'(if1.done); g.busy = int'(if1.busy); g.pass = int'(if1.pass);
    g.fail = int'(if1.fail); g.code = int'(if1.fail_code); g.idx = int'(if1.fail_idx);
    g.value = longint'(if1.fail_value); g.fcnt = int'(if1.fail_cnt);
    g.pcnt = int'(if1.pass_cnt); g.cyc = int'(if1.cycle_cnt); g.done_at = done_at;
    return g;
  endfunction

  function automatic exp_t snap0(int done_at);
    exp_t g;
    g.done = int'(if0.done); g.busy = int'(if0.busy); g.pass = int'(if0.pass);
    g.fail = int'(if0.fail); g.code = int'(if0.fail_code); g.idx = int'(if0.fail_idx);
    g.value = longint'(if0.fail_value); g.fcnt = int'(if0.fail_cnt);
    g.pcnt = int'(if0.pass_cnt); g.cyc = int'(if0.cycle_cnt); g.done_at = done_at;
    return g;
  endfunction

  task automatic cmp_all(input string tag, input exp_t g, input exp_t e);
    chk({tag, ".done"},       g.done,    e.done);
    chk({tag, ".busy"},       g.busy,    e.busy);
    chk({tag, ".pass"},       g.pass,    e.pass);
    chk({tag, ".fail"},       g.fail,    e.fail);
    chk({tag, ".fail_code"},  g.code,    e.code);
    chk({tag, ".fail_idx"},   g.idx,     e.idx);
    chk({tag, ".fail_value"}, g.value,   e.value);
    chk({tag, ".fail_cnt"},   g.fcnt,    e.fcnt);
    chk({tag, ".pass_cnt"},   g.pcnt,    e.pcnt);
    chk({tag, ".cycle_cnt"},  g.cyc,     e.cyc);
    chk({tag, ".done_edge"},  g.done_at, e.done_at);
  endtask

  // Drive the same core view into both instances.
  task automatic set_core(input int num, input longint out, input int halt);
    if1.num_inst = CNTW'(num); if0.num_inst = CNTW'(num);
    if1.output_port = DW'(out); if0.output_port = DW'(out);
    if1.halt = halt[0]; if0.halt = halt[0];
  endtask

  task automatic load(input int idx, input int num, input longint ans);
    if1.cfg_we = 1'b1; if0.cfg_we = 1'b1;
    if1.cfg_addr = 6'(idx); if0.cfg_addr = 6'(idx);
    if1.cfg_num_inst = CNTW'(num); if0.cfg_num_inst = CNTW'(num);
    if1.cfg_ans = DW'(ans); if0.cfg_ans = DW'(ans);
    @(posedge clk); #1;
    if1.cfg_we = 1'b0; if0.cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int nv);
    if1.cfg_num_valid = 6'(nv); if0.cfg_num_valid = 6'(nv);
    if1.start = 1'b1; if0.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0; if0.start = 1'b0;
  endtask

  // Starts a run and applies the whole stimulus history; records the edge
  // index (0 = first compare edge) at which each instance raised DONE.
  task automatic do_run(input string tag, input int nv, output int d1, output int d0);
    pulse_start(nv);
    chk({tag, ".busy_after_start.s1"}, int'(if1.busy), 1);
    chk({tag, ".busy_after_start.s0"}, int'(if0.busy), 1);
    d1 = -1; d0 = -1;
    for (int c = 0; c < LEN; c++) begin
      set_core(s_num[c], s_out[c], s_halt[c]);
      @(posedge clk); #1;
      if (d1 < 0 && if1.done) d1 = c;
      if (d0 < 0 && if0.done) d0 = c;
    end
    set_core(0, 0, 0);
  endtask

  // Reference model: walks the input history against the list of pending
  // checkpoints and returns the expected final status of one run.
  function automatic exp_t note(exp_t r, int code, int idx, longint val, int k);
    if (r.fail == 0) begin r.code = code; r.idx = idx; r.value = val; end
    r.fail = 1;
    r.fcnt += k;
    return r;
  endfunction

  function automatic exp_t model(input int nv, input int stop);
    exp_t r;
    int next = 0;
    int ended = 0;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, -1);
    r.cyc = 0;
    for (int c = 0; c < LEN && ended == 0; c++) begin
      int bad = 0;
      if (next < nv) begin
        if (s_num[c] == tnum[next]) begin
          if (s_out[c] == tans[next]) r.pcnt++;
          else begin r = note(r, 1, next, s_out[c], 1); bad = 1; end
          next++;
        end else if (s_num[c] > tnum[next]) begin
          r = note(r, 2, next, s_out[c], 1); bad = 1;
          next++;
        end
      end
      if (s_halt[c] != 0) begin
        if (next < nv) r = note(r, 3, next, s_out[c], nv - next);
        else r.pass = (r.fail == 0) ? 1 : 0;
        ended = 1;
      end else if (c + 1 == TMO) begin
        r = note(r, 4, next, s_out[c], 1);
        ended = 1;
      end else if (stop != 0 && bad != 0) begin
        ended = 1;
      end
      if (ended != 0) begin r.done = 1; r.done_at = c; r.cyc = c + 1; end
    end
    return r;
  endfunction

  function automatic longint ans_of(int n);
    if (n == 4) return 64'hF00;
    if (n == 6) return 64'h18;
    if (n == 8) return 64'h1D;
    return 64'hA000 + longint'(n);
  endfunction

  task automatic build_vec(input vec_t v);
    for (int c = 0; c < LEN; c++) begin
      int n;
      n = (v.freeze != 0) ? 0 : c + ((v.skip_n >= 0 && c >= v.skip_n) ? 1 : 0);
      s_num[c]  = n;
      s_out[c]  = (n == v.bad_n) ? 64'h19 : ans_of(n);
      s_halt[c] = (n == v.halt_n) ? 1 : 0;
    end
  endtask

  vec_t vecs [6];

  initial begin
    int d1, d0;
    exp_t z;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d0;
    exp_t z;
    vecs[0] = '{"pass",    3, 10, -1, -1, 0, mk(1,1,0,0,0,0,0,3,10),       mk(1,1,0,0,0,0,0,3,10)};
    vecs[1] = '{"mismatch",3, 10, -1,  6, 0, mk(1,0,1,1,1,'h19,1,1,6),     mk(1,0,1,1,1,'h19,1,2,10)};
    vecs[2] = '{"jump",    3, 10,  6, -1, 0, mk(1,0,1,2,1,'hA007,1,1,6),   mk(1,0,1,2,1,'hA007,1,2,9)};
    vecs[3] = '{"halt_early",3, 6, -1, -1, 0, mk(1,0,1,3,2,'h18,1,2,6),    mk(1,0,1,3,2,'h18,1,2,6)};
    vecs[4] = '{"timeout", 3, -1, -1, -1, 1, mk(1,0,1,4,0,'hA000,1,0,19),  mk(1,0,1,4,0,'hA000,1,0,19)};
    vecs[5] = '{"nvalid0", 0,  2, -1, -1, 0, mk(1,1,0,0,0,0,0,0,2),        mk(1,1,0,0,0,0,0,0,2)};

    if1.cfg_we = 0; if0.cfg_we = 0; if1.cfg_addr = 0; if0.cfg_addr = 0;
    if1.cfg_num_inst = 0; if0.cfg_num_inst = 0; if1.cfg_ans = 0; if0.cfg_ans = 0;
    if1.cfg_num_valid = 0; if0.cfg_num_valid = 0; if1.start = 0; if0.start = 0;
    set_core(0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, -1);
    z.cyc = 0;
    cmp_all("reset.s1", snap1(-1), z);
    cmp_all("reset.s0", snap0(-1), z);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the {4:0xF00, 6:0x18, 8:0x1D} table.
    load(0, 4, 64'hF00);
    load(1, 6, 64'h18);
    load(2, 8, 64'h1D);
    for (int i = 0; i < 6; i++) begin
      build_vec(vecs[i]);
      do_run(vecs[i].name, vecs[i].nv, d1, d0);
      cmp_all({vecs[i].name, ".s1"}, snap1(d1), vecs[i].e1);
      cmp_all({vecs[i].name, ".s0"}, snap0(d0), vecs[i].e0);
      $display("vec %s: done edge s1=%0d s0=%0d fail_code s1=%0d s0=%0d",
               vecs[i].name, d1, d0, if1.fail_code, if0.fail_code);
    end

    // Table write during RUN is ignored, then asynchronous reset mid-run.
    build_vec(vecs[0]);
    pulse_start(3);
    for (int c = 0; c < 3; c++) begin
      set_core(c, ans_of(c), 0);
      @(posedge clk); #1;
    end
    if1.cfg_we = 1'b1; if0.cfg_we = 1'b1;
    if1.cfg_addr = 6'd0; if0.cfg_addr = 6'd0;
    if1.cfg_num_inst = 32'd3; if0.cfg_num_inst = 32'd3;
    if1.cfg_ans = 32'd0; if0.cfg_ans = 32'd0;
    set_core(3, 0, 0);
    @(posedge clk); #1;
    if1.cfg_we = 1'b0; if0.cfg_we = 1'b0;
    chk("midrun.cycle_cnt.s1", longint'(if1.cycle_cnt), 4);
    chk("midrun.busy.s1", int'(if1.busy), 1);
    #3 rst_n = 1'b0;
    #1;
    cmp_all("async_reset.s1", snap1(-1), z);
    cmp_all("async_reset.s0", snap0(-1), z);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_idle.busy.s1", int'(if1.busy), 0);
    chk("after_reset_idle.cycle_cnt.s1", longint'(if1.cycle_cnt), 0);
    do_run("table_kept", 3, d1, d0);
    cmp_all("table_kept.s1", snap1(d1), vecs[0].e1);
    cmp_all("table_kept.s0", snap0(d0), vecs[0].e0);
    $display("seq reset_midrun: rerun done edge s1=%0d s0=%0d", d1, d0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      int nv, t, n, hc;
      nv = $urandom_range(0, 5);
      t  = $urandom_range(1, 3);
      for (int i = 0; i < nv; i++) begin
        tnum[i] = t;
        tans[i] = $urandom_range(0, 3);
        load(i, tnum[i], tans[i]);
        t += $urandom_range(1, 3);
      end
      n  = 0;
      hc = $urandom_range(3, 26);
      for (int c = 0; c < LEN; c++) begin
        int j;
        j = -1;
        for (int i = 0; i < nv; i++) if (tnum[i] == n) j = i;
        s_num[c]  = n;
        s_out[c]  = (j >= 0 && $urandom_range(0, 4) != 0) ? tans[j] : longint'($urandom_range(0, 3));
        s_halt[c] = (c == hc) ? 1 : 0;
        n += $urandom_range(0, 2);
      end
      do_run($sformatf("rand%0d", r), nv, d1, d0);
      cmp_all($sformatf("rand%0d.s1", r), snap1(d1), model(nv, 1));
      cmp_all($sformatf("rand%0d.s0", r), snap0(d0), model(nv, 0));
      $display("rand %0d: nvalid=%0d halt_cycle=%0d done edge s1=%0d s0=%0d pass s1=%0d s0=%0d",
               r, nv, hc, d1, d0, if1.pass, if0.pass);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_checkpoint_monitor.md
# riscv_checkpoint_monitor

Synthesizable checkpoint monitor for the RISC-V core. It watches the core's retired-instruction counter and output port and checks them against a loadable table of (instruction count, expected value) checkpoints. It reports pass, fail, or timeout through sticky status outputs. It sits beside RISCV_TOP and is fed by NUM_INST, OUTPUT_PORT and HALT, so the same self-check works in simulation and on FPGA.

## Interface
- NUM_CKPT, 40, checkpoint table depth; AW = $clog2(NUM_CKPT), CW = $clog2(NUM_CKPT+1)
- DWIDTH, 32, width of OUTPUT_PORT and expected values
- CNT_WIDTH, 32, width of NUM_INST, table counts and CYCLE_CNT
- TIMEOUT, 1000000, RUN cycles before timeout; 0 disables the timeout
- STOP_ON_FAIL, 1, 1 = end the run at the first failure; 0 = log the first failure and keep checking
- CLK  in  1  clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- CFG_WE  in  1  table write strobe; honoured in IDLE/DONE only
- CFG_ADDR  in  AW  table entry index
- CFG_NUM_INST  in  CNT_WIDTH  checkpoint instruction count
- CFG_ANS  in  DWIDTH  expected OUTPUT_PORT value
- CFG_NUM_VALID  in  CW  number of valid entries; sampled on START
- START  in  1  one-cycle pulse: IDLE/DONE -> RUN
- NUM_INST  in  CNT_WIDTH  core retired-instruction count
- OUTPUT_PORT  in  DWIDTH  core output port
- HALT  in  1  core halt
- BUSY  out  1  high in RUN
- DONE  out  1  sticky; high in DONE
- PASS  out  1  sticky; all entries matched and HALT seen, with no failure
- FAIL  out  1  sticky; at least one failure
- FAIL_CODE  out  3  first-failure cause: 0 none, 1 mismatch, 2 skipped, 3 incomplete at HALT, 4 timeout
- FAIL_IDX  out  AW  entry index of the first failure
- FAIL_VALUE  out  DWIDTH  OUTPUT_PORT captured at the first failure
- FAIL_CNT  out  CW  total failed entries
- PASS_CNT  out  CW  total matched entries
- CYCLE_CNT  out  CNT_WIDTH  RUN cycles elapsed; saturates at all-ones

## Operation
- The table is a register array and is not reset. Entries must be loaded with NUM_INST values strictly increasing with index; duplicate or out-of-order entries are unsupported.
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE/DONE -> RUN on START:
  - latch CFG_NUM_VALID into nvalid;
  - set ptr=0;
  - clear all status outputs and counters.
- RUN, each cycle, with e = table[ptr], while ptr < nvalid:
  - NUM_INST == e.num: compare OUTPUT_PORT with e.ans. Equal increments PASS_CNT; unequal is failure code 1. Then ptr++.
  - NUM_INST > e.num: failure code 2 (the count jumped past the entry). Then ptr++. Only one entry is consumed per cycle.
  - NUM_INST < e.num: no action.
- HALT in RUN is evaluated after that cycle's compare:
  - ptr (post-update) < nvalid: failure code 3, FAIL_IDX = ptr, FAIL_CNT += nvalid - ptr.
  - otherwise: PASS = !FAIL.
  - Either way, -> DONE.
- Timeout: CYCLE_CNT reaches TIMEOUT in RUN (TIMEOUT != 0) -> failure code 4, FAIL_IDX = ptr, -> DONE.
- On any failure: FAIL_CNT++. If FAIL was low, capture FAIL_CODE, FAIL_IDX and FAIL_VALUE (FAIL_VALUE = OUTPUT_PORT).
- STOP_ON_FAIL=1: any failure -> DONE.
- STOP_ON_FAIL=0: only HALT or timeout -> DONE.
- nvalid = 0: the run passes at the first HALT.
- CFG_WE and START are ignored in RUN.
- In DONE, every output holds until START or reset.

## Timing
- Reset values:
  - state IDLE;
  - BUSY, DONE, PASS, FAIL = 0;
  - FAIL_CODE, FAIL_IDX, FAIL_VALUE = 0;
  - FAIL_CNT, PASS_CNT, CYCLE_CNT = 0.
- START sampled at edge k: BUSY=1 after edge k. The first compare uses inputs sampled at edge k+1.
- Inputs are sampled at edge n; PASS_CNT, FAIL and FAIL_* reflect them after edge n; DONE is high after edge n.
- CYCLE_CNT increments at every RUN edge, including the edge that exits to DONE.
- Same-cycle HALT and matching entry: the entry is checked first, then HALT is evaluated.
- Same-cycle timeout and HALT: HALT takes priority.
- Same-cycle timeout and mismatch: the mismatch is the first failure.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous). The table is preserved.

## Test plan
- Load 3 entries {4:0xF00, 6:0x18, 8:0x1D}; drive NUM_INST 0..10 with correct OUTPUT_PORT; HALT at 10 -> PASS=1, PASS_CNT=3, FAIL_CNT=0, DONE one edge after HALT.
- Same table, OUTPUT_PORT=0x19 at NUM_INST=6, STOP_ON_FAIL=1 -> FAIL=1, FAIL_CODE=1, FAIL_IDX=1, FAIL_VALUE=0x19, DONE after that edge, PASS_CNT=1.
- Same mismatch with STOP_ON_FAIL=0, rest correct, HALT -> DONE on HALT, FAIL_CNT=1, PASS_CNT=2, PASS=0.
- NUM_INST jumps 5->7 -> FAIL_CODE=2, FAIL_IDX=1.
- HALT at NUM_INST=6 (before entry 8) with STOP_ON_FAIL=0 -> FAIL_CODE=3, FAIL_IDX=2, FAIL_CNT=1.
- TIMEOUT=20, NUM_INST frozen at 0 -> DONE with FAIL_CODE=4 after 20 RUN edges. Reset mid-run clears all outputs and the FSM returns to IDLE.
